// File: rtl/xy_input_port.sv
// xy_input_port: per-input front end of a mesh switch.
// Buffers incoming flits, extracts the destination of each head flit for the
// downstream xy_router, holds the returned output port for the whole packet
// and requests the crossbar until the tail flit has been granted.
// Optional feature: define INPORT_DROP_CNT_EN to add drop_cnt_o, a saturating
// count of BODY/TAIL flits discarded while no packet is open.
module xy_input_port #(
  parameter int unsigned DATA_W            = 8,
  parameter int unsigned PACKET_ADDR_COL_W = 4,
  parameter int unsigned PACKET_ADDR_ROW_W = 4,
  parameter int unsigned OUTPUT_N_W        = 3,
  parameter int unsigned FIFO_DEPTH        = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [DATA_W+1:0]            data_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [PACKET_ADDR_COL_W-1:0] col_addr_o,
  output logic [PACKET_ADDR_ROW_W-1:0] row_addr_o,
  input  logic [OUTPUT_N_W-1:0]        route_sel_i,
  output logic                         req_o,
  output logic [OUTPUT_N_W-1:0]        out_sel_o,
  input  logic                         grant_i,
  output logic [DATA_W+1:0]            data_o
`ifdef INPORT_DROP_CNT_EN
  ,
  output logic [7:0]                   drop_cnt_o
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    FT_HEADTAIL = 2'b00,
    FT_HEAD     = 2'b01,
    FT_BODY     = 2'b10,
    FT_TAIL     = 2'b11
  } flit_type_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_ACTIVE
  } state_t;

  logic [DATA_W+1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              empty, full, push, pop;
  logic [DATA_W+1:0] front;
  flit_type_t        front_type;
  logic              front_is_head, front_ends_pkt;

  state_t            state, state_n;
  logic              head_latch, route_latch, drop;

  assign empty          = (count == '0);
  assign full           = (count == CNT_W'(FIFO_DEPTH));
  assign ready_o        = !full;
  assign push           = valid_i && !full;
  assign front          = mem[rd_ptr];
  assign front_type     = flit_type_t'(front[DATA_W+1:DATA_W]);
  assign front_is_head  = (front_type == FT_HEAD) || (front_type == FT_HEADTAIL);
  assign front_ends_pkt = (front_type == FT_TAIL) || (front_type == FT_HEADTAIL);
  // Memory is never reset, so an empty buffer presents zero instead of stale data.
  assign data_o         = empty ? '0 : front;

  // Flit storage write port (no reset on the array).
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= data_i;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Packet FSM state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_IDLE;
    else         state <= state_n;
  end

  // Next-state, pop and request decode.
  always_comb begin
    state_n     = state;
    pop         = 1'b0;
    head_latch  = 1'b0;
    route_latch = 1'b0;
    drop        = 1'b0;
    req_o       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          if (front_is_head) begin
            head_latch = 1'b1;
            state_n    = ST_ROUTE;
          end else begin
            pop  = 1'b1;
            drop = 1'b1;
          end
        end
      end
      ST_ROUTE: begin
        route_latch = 1'b1;
        state_n     = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        req_o = !empty;
        if (req_o && grant_i) begin
          pop = 1'b1;
          if (front_ends_pkt) state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Destination address held from head detection until the next head.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      col_addr_o <= '0;
      row_addr_o <= '0;
    end else if (head_latch) begin
      col_addr_o <= front[PACKET_ADDR_COL_W-1:0];
      row_addr_o <= front[PACKET_ADDR_COL_W+PACKET_ADDR_ROW_W-1:PACKET_ADDR_COL_W];
    end
  end

  // Router decision captured once per packet.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)          out_sel_o <= '0;
    else if (route_latch) out_sel_o <= route_sel_i;
  end

`ifdef INPORT_DROP_CNT_EN
  // Saturating count of orphan BODY/TAIL flits discarded in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                      drop_cnt_o <= '0;
    else if (drop && drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 8'd1;
  end
`endif

endmodule

// File: tb/tb_xy_input_port.sv
// Bench for xy_input_port: directed scenarios with literal expectations plus
// randomized packet traffic, all checked every cycle against a packet-level
// reference model of the port.
module tb_xy_input_port;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic       grant_i = 1'b0;
  logic       ready_o, req_o;
  logic [3:0] col_addr_o, row_addr_o;
  logic [2:0] route_sel_i, out_sel_o;
  logic [9:0] data_o;
`ifdef INPORT_DROP_CNT_EN
  logic [7:0] drop_cnt_o;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  bit          rand_grant = 1'b0;

  always #5 clk = ~clk;

  // Stand-in for the xy_router: any fixed function of the latched address.
  function automatic logic [2:0] route_fn(input logic [3:0] c, input logic [3:0] r);
    return 3'(c + r);
  endfunction

  assign route_sel_i = route_fn(col_addr_o, row_addr_o);

  xy_input_port #(
    .DATA_W(8),
    .PACKET_ADDR_COL_W(4),
    .PACKET_ADDR_ROW_W(4),
    .OUTPUT_N_W(3),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .data_i(data_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .col_addr_o(col_addr_o),
    .row_addr_o(row_addr_o),
    .route_sel_i(route_sel_i),
    .req_o(req_o),
    .out_sel_o(out_sel_o),
    .grant_i(grant_i),
    .data_o(data_o)
`ifdef INPORT_DROP_CNT_EN
    ,
    .drop_cnt_o(drop_cnt_o)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] mk(input logic [1:0] t, input logic [3:0] c, input logic [3:0] r);
    return {t, r, c};
  endfunction

  // ---------------- reference model ----------------
  // Buffered flits, whether a packet is open, whether its route is still
  // being looked up, and the address/port the packet is bound to.
  logic [9:0] mq[$];
  bit         m_open, m_lookup;
  logic [2:0] m_port;
  logic [3:0] m_col, m_row;
  int         m_drops;
  bit         m_push;
  logic [9:0] mf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_open = 0; m_lookup = 0; m_port = '0; m_col = '0; m_row = '0; m_drops = 0;
    end else begin
      m_push = valid_i && (mq.size() < DEPTH);
      if (!m_open) begin
        if (mq.size() > 0) begin
          mf = mq[0];
          if (mf[9:8] == 2'b01 || mf[9:8] == 2'b00) begin
            m_col = mf[3:0]; m_row = mf[7:4]; m_open = 1; m_lookup = 1;
          end else begin
            void'(mq.pop_front());
            if (m_drops < 255) m_drops++;
          end
        end
      end else if (m_lookup) begin
        m_port = route_fn(m_col, m_row);
        m_lookup = 0;
      end else if (mq.size() > 0 && grant_i) begin
        mf = mq.pop_front();
        if (mf[9:8] == 2'b11 || mf[9:8] == 2'b00) m_open = 0;
      end
      if (m_push) mq.push_back(data_i);
    end
  end

  // Compare every cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", ready_o, int'(mq.size() < DEPTH));
      chk("req", req_o, int'(m_open && !m_lookup && mq.size() > 0));
      if (m_open && !m_lookup && mq.size() > 0) chk("data", data_o, mq[0]);
      chk("out_sel", out_sel_o, m_port);
      chk("col", col_addr_o, m_col);
      chk("row", row_addr_o, m_row);
`ifdef INPORT_DROP_CNT_EN
      chk("drop_cnt", drop_cnt_o, m_drops);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
    if (rand_grant) grant_i = ($urandom_range(3) != 0);
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [9:0] f);
    bit acc;
    int guard;
    data_i = f; valid_i = 1'b1; acc = 0; guard = 0;
    while (!acc && guard < 200) begin
      acc = ready_o;
      step();
      guard++;
    end
    valid_i = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", ready_o, 1);
    chk("rst_req", req_o, 0);
    chk("rst_out_sel", out_sel_o, 0);
    chk("rst_col", col_addr_o, 0);
    chk("rst_row", row_addr_o, 0);
    chk("rst_data", data_o, 0);
    rst_n = 1'b1;
    step();

    // Basic three-flit packet with continuous grant
    grant_i = 1'b1;
    send(mk(2'b01, 4'd2, 4'd1));
    send(mk(2'b10, 4'hA, 4'h5));
    send(mk(2'b11, 4'hC, 4'h3));
    chk("t2_req_c3", req_o, 1);
    chk("t2_sel_c3", out_sel_o, 3);
    chk("t2_data_c3", data_o, 10'h112);
    step();
    chk("t2_data_c4", data_o, 10'h25A);
    step();
    chk("t2_data_c5", data_o, 10'h33C);
    step();
    chk("t2_req_c6", req_o, 0);

    // Reset in the middle of a packet
    grant_i = 1'b0;
    send(mk(2'b01, 4'd5, 4'd2));
    send(mk(2'b10, 4'd1, 4'd1));
    idle(3);
    chk("t1_req_before", req_o, 1);
    chk("t1_sel_before", out_sel_o, 7);
    rst_n = 1'b0;
    #1;
    chk("t1_ready", ready_o, 1);
    chk("t1_req", req_o, 0);
    chk("t1_out_sel", out_sel_o, 0);
    chk("t1_data", data_o, 0);
    step();
    rst_n = 1'b1;
    step();

    // Fill the buffer with no grant, then release one slot
    grant_i = 1'b0;
    send(mk(2'b01, 4'd1, 4'd1));
    send(mk(2'b10, 4'd1, 4'd0));
    send(mk(2'b10, 4'd2, 4'd0));
    send(mk(2'b11, 4'd3, 4'd0));
    chk("t3_full", ready_o, 0);
    data_i = mk(2'b10, 4'd4, 4'd0);
    valid_i = 1'b1;
    step();
    step();
    valid_i = 1'b0;
    chk("t3_still_full", ready_o, 0);
    grant_i = 1'b1;
    step();
    grant_i = 1'b0;
    chk("t3_ready_after_pop", ready_o, 1);
    grant_i = 1'b1;
    idle(6);

    // Orphan BODY/TAIL discarded, HEADTAIL forwarded
    send(mk(2'b10, 4'd7, 4'd7));
    send(mk(2'b11, 4'd6, 4'd6));
    send(mk(2'b00, 4'd0, 4'd0));
    idle(6);
    chk("t4_out_sel", out_sel_o, 0);
`ifdef INPORT_DROP_CNT_EN
    chk("t4_drop_cnt", drop_cnt_o, 2);
`endif

    // Gap inside a packet
    send(mk(2'b01, 4'd3, 4'd3));
    idle(5);
    chk("t5_req_gap", req_o, 0);
    chk("t5_sel_held", out_sel_o, 6);
    send(mk(2'b11, 4'd9, 4'd9));
    idle(3);
    chk("t5_req_end", req_o, 0);

    // Steady push+pop at occupancy two
    grant_i = 1'b0;
    send(mk(2'b01, 4'd4, 4'd0));
    send(mk(2'b10, 4'd15, 4'd15));
    idle(1);
    grant_i = 1'b1;
    for (int i = 0; i < 10; i++) send(mk(2'b10, 4'(i), 4'd8));
    chk("t6_ready", ready_o, 1);
    send(mk(2'b11, 4'd0, 4'd9));
    idle(6);

    // Randomized traffic with random grant and one reset
    rand_grant = 1'b1;
    for (int p = 0; p < 60; p++) begin
      if (p == 30) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
      end
      if ($urandom_range(4) == 0)
        send(mk($urandom_range(1) ? 2'b10 : 2'b11, 4'($urandom), 4'($urandom)));
      if ($urandom_range(3) == 0) begin
        send(mk(2'b00, 4'($urandom), 4'($urandom)));
      end else begin
        send(mk(2'b01, 4'($urandom), 4'($urandom)));
        for (int b = 0; b < int'($urandom_range(4)); b++) begin
          send(mk(2'b10, 4'($urandom), 4'($urandom)));
          if ($urandom_range(3) == 0) idle(int'($urandom_range(3)));
        end
        send(mk(2'b11, 4'($urandom), 4'($urandom)));
      end
      idle(int'($urandom_range(2)));
    end
    rand_grant = 1'b0;
    grant_i = 1'b1;
    idle(20);
    chk("drain_req", req_o, 0);
    chk("drain_ready", ready_o, 1);
    chk("drain_model_empty", int'(mq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
